usb_sie_phase_ctrl: RTL and testbench

//  Half-duplex phase controller for the full-speed SIE. It decides when the SIE is in the send

---
 rtl/sie_defs_pkg.sv | 31 +++
 rtl/usb_bit_timer.sv | 40 ++++
 rtl/usb_sie_phase_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_usb_sie_phase_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sie_defs_pkg.sv
`default_nettype none
// ============================================================================
// sie_defs_pkg : phase-controller states and default timing constants
// Revision     : 1.0
// ============================================================================
package sie_defs_pkg;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_BUSY      = 3'd1,
      TX_ACTIVE    = 3'd2,
      TX_WAIT_RESP = 3'd3,
      USB_RST      = 3'd4
   } sie_phase_t;

   localparam int CLK_PER_BIT_DEF       = 4;
   localparam int TURNAROUND_BITS_DEF   = 2;
   localparam int RESP_TIMEOUT_BITS_DEF = 18;
   localparam int CNT_WIDTH_DEF         = 8;

   localparam int NUM_CNT     = 3;
   localparam int CNT_RX_PKT  = 0;
   localparam int CNT_RX_ERR  = 1;
   localparam int CNT_TIMEOUT = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/usb_bit_timer.sv
`default_nettype none
// ============================================================================
// usb_bit_timer : loadable down-counter used for gap and response timing
// Revision      : 1.0
// ============================================================================
module usb_bit_timer #(
   parameter int WIDTH = 7
) (
   input  logic             clk48_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   output logic             done_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk48_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flags the edge on which the count lands on zero, so a load of N is acted on N edges later.
   assign done_o = (cnt_q <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/usb_sie_phase_ctrl.sv
`default_nettype none
// ============================================================================
// usb_sie_phase_ctrl : half-duplex send/receive phase control for the FS SIE
// Revision           : 1.0
// ============================================================================
module usb_sie_phase_ctrl
   import sie_defs_pkg::*;
#(
   parameter int CLK_PER_BIT       = CLK_PER_BIT_DEF,
   parameter int TURNAROUND_BITS   = TURNAROUND_BITS_DEF,
   parameter int RESP_TIMEOUT_BITS = RESP_TIMEOUT_BITS_DEF,
   parameter int CNT_WIDTH         = CNT_WIDTH_DEF
) (
   input  logic                 clk48_i,
   input  logic                 rst_i,
   input  logic                 rxActive_i,
   input  logic                 rxPacketEnd_i,
   input  logic                 rxKeepPacket_i,
   input  logic                 txReq_i,
   input  logic                 txExpectResp_i,
   input  logic                 txDoneSending_i,
   input  logic                 usbResetDetected_i,
   input  logic                 clrCnt_i,
   output logic                 isSendingPhase_o,
   output logic                 txGrant_o,
   output logic                 dpplRst_o,
   output logic                 respTimeout_o,
   output logic                 ackUsbResetDetect_o,
   output logic [CNT_WIDTH-1:0] rxPktCnt_o,
   output logic [CNT_WIDTH-1:0] rxErrCnt_o,
   output logic [CNT_WIDTH-1:0] timeoutCnt_o
);

   localparam int TMR_W = $clog2(max_int(TURNAROUND_BITS, RESP_TIMEOUT_BITS) * CLK_PER_BIT + 1);
   localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(TURNAROUND_BITS * CLK_PER_BIT);
   localparam logic [TMR_W-1:0] RESP_LOAD = TMR_W'(RESP_TIMEOUT_BITS * CLK_PER_BIT);

   sie_phase_t state_q, state_d;
   logic sending_q, sending_d;
   logic grant_q, grant_d;
   logic dppl_rst_q, dppl_rst_d;
   logic resp_tmo_q, resp_tmo_d;
   logic ack_q, ack_d;
   logic expect_q, expect_d;

   logic             gap_load, resp_load, gap_done, resp_done;
   logic [TMR_W-1:0] gap_value, resp_value;
   logic [NUM_CNT-1:0]   cnt_inc;
   logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];

   usb_bit_timer #(.WIDTH(TMR_W)) u_gap_timer (
      .clk48_i (clk48_i),
      .rst_i   (rst_i),
      .load_i  (gap_load),
      .value_i (gap_value),
      .done_o  (gap_done)
   );

   usb_bit_timer #(.WIDTH(TMR_W)) u_resp_timer (
      .clk48_i (clk48_i),
      .rst_i   (rst_i),
      .load_i  (resp_load),
      .value_i (resp_value),
      .done_o  (resp_done)
   );

   always_comb begin
      state_d    = state_q;
      sending_d  = sending_q;
      grant_d    = 1'b0;
      dppl_rst_d = 1'b0;
      resp_tmo_d = 1'b0;
      ack_d      = 1'b0;
      expect_d   = expect_q;
      gap_load   = 1'b0;
      gap_value  = GAP_LOAD;
      resp_load  = 1'b0;
      resp_value = RESP_LOAD;
      cnt_inc    = '0;
      if (usbResetDetected_i) begin
         // Bus reset overrides everything; an interrupted transmit still resyncs the DPPL once.
         state_d    = USB_RST;
         sending_d  = 1'b0;
         ack_d      = 1'b1;
         dppl_rst_d = (state_q == TX_ACTIVE);
         gap_load   = 1'b1;
         gap_value  = '0;
         resp_load  = 1'b1;
         resp_value = '0;
      end else begin
         case (state_q)
            RX_IDLE: begin
               if (rxActive_i) begin
                  state_d = RX_BUSY;
               end else if (txReq_i && gap_done) begin
                  state_d   = TX_ACTIVE;
                  sending_d = 1'b1;
                  grant_d   = 1'b1;
                  expect_d  = txExpectResp_i;
               end
            end
            RX_BUSY: begin
               if (rxPacketEnd_i) begin
                  state_d             = RX_IDLE;
                  gap_load            = 1'b1;
                  cnt_inc[CNT_RX_PKT] = 1'b1;
                  cnt_inc[CNT_RX_ERR] = !rxKeepPacket_i;
               end
            end
            TX_ACTIVE: begin
               if (txDoneSending_i) begin
                  sending_d  = 1'b0;
                  dppl_rst_d = 1'b1;
                  if (expect_q) begin
                     state_d   = TX_WAIT_RESP;
                     resp_load = 1'b1;
                  end else begin
                     state_d  = RX_IDLE;
                     gap_load = 1'b1;
                  end
               end
            end
            TX_WAIT_RESP: begin
               if (rxActive_i) begin
                  state_d = RX_BUSY;
               end else if (resp_done) begin
                  state_d              = RX_IDLE;
                  resp_tmo_d           = 1'b1;
                  gap_load             = 1'b1;
                  cnt_inc[CNT_TIMEOUT] = 1'b1;
               end
            end
            USB_RST: begin
               state_d = RX_IDLE;
            end
            default: begin
               state_d   = RX_IDLE;
               sending_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk48_i) begin
      if (rst_i) begin
         state_q    <= RX_IDLE;
         sending_q  <= 1'b0;
         grant_q    <= 1'b0;
         dppl_rst_q <= 1'b0;
         resp_tmo_q <= 1'b0;
         ack_q      <= 1'b0;
         expect_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         sending_q  <= sending_d;
         grant_q    <= grant_d;
         dppl_rst_q <= dppl_rst_d;
         resp_tmo_q <= resp_tmo_d;
         ack_q      <= ack_d;
         expect_q   <= expect_d;
      end
   end

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (clrCnt_i) begin
            cnt_d = '0;
         end else if (cnt_inc[g] && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk48_i) begin
         if (rst_i) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign cnt_val[g] = cnt_q;
   end

   assign isSendingPhase_o    = sending_q;
   assign txGrant_o           = grant_q;
   assign dpplRst_o           = dppl_rst_q;
   assign respTimeout_o       = resp_tmo_q;
   assign ackUsbResetDetect_o = ack_q;
   assign rxPktCnt_o          = cnt_val[CNT_RX_PKT];
   assign rxErrCnt_o          = cnt_val[CNT_RX_ERR];
   assign timeoutCnt_o        = cnt_val[CNT_TIMEOUT];

endmodule
`default_nettype wire

// File: tb/tb_usb_sie_phase_ctrl.sv
`default_nettype none
// ============================================================================
// tb_usb_sie_phase_ctrl : directed vector bench for usb_sie_phase_ctrl
// Revision              : 1.0
// ============================================================================
module tb_usb_sie_phase_ctrl;

   // in  = {rst, usb_rst, clr, rx_active, rx_end, keep, tx_req, expect, tx_done}
   // out = {sending, grant, dppl_rst, resp_timeout, ack}
   typedef struct packed {
      logic [8:0] in;
      logic [4:0] out;
      logic [7:0] pkt;
      logic [7:0] err;
      logic [7:0] tmo;
   } vec_t;

   logic       clk48_i = 1'b0;
   logic       rst_i = 1'b0, rxActive_i = 1'b0, rxPacketEnd_i = 1'b0, rxKeepPacket_i = 1'b0;
   logic       txReq_i = 1'b0, txExpectResp_i = 1'b0, txDoneSending_i = 1'b0;
   logic       usbResetDetected_i = 1'b0, clrCnt_i = 1'b0;
   logic       isSendingPhase_o, txGrant_o, dpplRst_o, respTimeout_o, ackUsbResetDetect_o;
   logic [7:0] rxPktCnt_o, rxErrCnt_o, timeoutCnt_o;

   int n_cmp = 0;
   int n_err = 0;
   vec_t vecs[$];

   always #5 clk48_i = ~clk48_i;

   usb_sie_phase_ctrl dut (
      .clk48_i             (clk48_i),
      .rst_i               (rst_i),
      .rxActive_i          (rxActive_i),
      .rxPacketEnd_i       (rxPacketEnd_i),
      .rxKeepPacket_i      (rxKeepPacket_i),
      .txReq_i             (txReq_i),
      .txExpectResp_i      (txExpectResp_i),
      .txDoneSending_i     (txDoneSending_i),
      .usbResetDetected_i  (usbResetDetected_i),
      .clrCnt_i            (clrCnt_i),
      .isSendingPhase_o    (isSendingPhase_o),
      .txGrant_o           (txGrant_o),
      .dpplRst_o           (dpplRst_o),
      .respTimeout_o       (respTimeout_o),
      .ackUsbResetDetect_o (ackUsbResetDetect_o),
      .rxPktCnt_o          (rxPktCnt_o),
      .rxErrCnt_o          (rxErrCnt_o),
      .timeoutCnt_o        (timeoutCnt_o)
   );

   function automatic vec_t mk(input logic [8:0] i, input logic [4:0] o,
                               input int p, input int e, input int t);
      vec_t v;
      v.in  = i;
      v.out = o;
      v.pkt = 8'(p);
      v.err = 8'(e);
      v.tmo = 8'(t);
      return v;
   endfunction

   function automatic void chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   function automatic int outs();
      return int'({isSendingPhase_o, txGrant_o, dpplRst_o, respTimeout_o, ackUsbResetDetect_o});
   endfunction

   task automatic drive(input logic [8:0] i);
      {rst_i, usbResetDetected_i, clrCnt_i, rxActive_i, rxPacketEnd_i,
       rxKeepPacket_i, txReq_i, txExpectResp_i, txDoneSending_i} = i;
   endtask

   task automatic tick();
      @(posedge clk48_i);
      #1;
   endtask

   task automatic chk_cnt(input string name, input int p, input int e, input int t);
      chk({name, ".pkt"}, int'(rxPktCnt_o), p);
      chk({name, ".err"}, int'(rxErrCnt_o), e);
      chk({name, ".tmo"}, int'(timeoutCnt_o), t);
   endtask

   // Requests a transmit and reports how many edges pass before the grant shows.
   task automatic wait_grant(input logic exp_resp, input int exp_k, input string name);
      int k;
      k = 0;
      txReq_i = 1'b1;
      txExpectResp_i = exp_resp;
      do begin
         tick();
         k++;
      end while (!txGrant_o && k < 40);
      chk(name, k, exp_k);
      chk({name, ".sending"}, int'(isSendingPhase_o), 1);
      txReq_i = 1'b0;
      txExpectResp_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int k;
      int seen;

      vecs.push_back(mk(9'b100000000, 5'b00000, 0, 0, 0)); // reset
      vecs.push_back(mk(9'b000000100, 5'b11000, 0, 0, 0)); // immediate grant
      vecs.push_back(mk(9'b000000000, 5'b10000, 0, 0, 0)); // sending held
      vecs.push_back(mk(9'b000000001, 5'b00100, 0, 0, 0)); // done, dppl resync
      vecs.push_back(mk(9'b000100000, 5'b00000, 0, 0, 0)); // rx busy
      vecs.push_back(mk(9'b000110000, 5'b00000, 1, 1, 0)); // corrupt packet
      vecs.push_back(mk(9'b000000100, 5'b00000, 1, 1, 0)); // gap blocks grant
      vecs.push_back(mk(9'b100000100, 5'b00000, 0, 0, 0)); // reset clears counts

      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].in);
         tick();
         chk($sformatf("vec%0d.out", i), outs(), int'(vecs[i].out));
         chk_cnt($sformatf("vec%0d", i), int'(vecs[i].pkt), int'(vecs[i].err), int'(vecs[i].tmo));
      end
      drive(9'b0);

      // turnaround gap after a good packet
      rxActive_i = 1'b1;
      tick();
      rxActive_i = 1'b0;
      rxPacketEnd_i = 1'b1;
      rxKeepPacket_i = 1'b1;
      tick();
      rxPacketEnd_i = 1'b0;
      rxKeepPacket_i = 1'b0;
      wait_grant(1'b0, 8, "gap_grant");
      chk_cnt("gap", 1, 0, 0);

      // response timeout
      txDoneSending_i = 1'b1;
      tick();
      txDoneSending_i = 1'b0;
      wait_grant(1'b1, 8, "resp_grant");
      txDoneSending_i = 1'b1;
      tick();
      txDoneSending_i = 1'b0;
      chk("tx_end.out", outs(), 5'b00100);
      k = 0;
      do begin
         tick();
         k++;
      end while (!respTimeout_o && k < 100);
      chk("timeout_latency", k, 72);
      chk_cnt("timeout", 1, 0, 1);

      // response arrives on the expiry edge: reception wins
      wait_grant(1'b1, 8, "resp2_grant");
      txDoneSending_i = 1'b1;
      tick();
      txDoneSending_i = 1'b0;
      seen = 0;
      for (int j = 1; j <= 72; j++) begin
         rxActive_i = (j == 72);
         tick();
         if (respTimeout_o) seen++;
      end
      rxActive_i = 1'b0;
      chk("late_resp.timeouts", seen, 0);
      txReq_i = 1'b1;
      seen = 0;
      for (int j = 0; j < 4; j++) begin
         tick();
         if (txGrant_o) seen++;
      end
      txReq_i = 1'b0;
      chk("busy.no_grant", seen, 0);
      rxPacketEnd_i = 1'b1;
      rxKeepPacket_i = 1'b1;
      tick();
      rxPacketEnd_i = 1'b0;
      rxKeepPacket_i = 1'b0;
      chk_cnt("late_resp", 2, 0, 1);

      // bus reset in the middle of a transmit
      wait_grant(1'b0, 8, "pre_rst_grant");
      usbResetDetected_i = 1'b1;
      tick();
      chk("usb_rst.first", outs(), 5'b00101);
      tick();
      chk("usb_rst.hold", outs(), 5'b00001);
      usbResetDetected_i = 1'b0;
      tick();
      chk("usb_rst.release", outs(), 5'b00000);
      chk_cnt("usb_rst", 2, 0, 1);
      wait_grant(1'b0, 1, "post_rst_grant");
      txDoneSending_i = 1'b1;
      tick();
      txDoneSending_i = 1'b0;

      // saturation, then clear racing an increment
      for (int j = 0; j < 300; j++) begin
         rxActive_i = 1'b1;
         tick();
         rxActive_i = 1'b0;
         rxPacketEnd_i = 1'b1;
         tick();
         rxPacketEnd_i = 1'b0;
      end
      chk_cnt("saturate", 255, 255, 1);
      rxActive_i = 1'b1;
      tick();
      rxActive_i = 1'b0;
      rxPacketEnd_i = 1'b1;
      clrCnt_i = 1'b1;
      tick();
      rxPacketEnd_i = 1'b0;
      clrCnt_i = 1'b0;
      chk_cnt("clear", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
